// File: rtl/imem_loader.sv
// Boot-time loader: packs a little-endian byte stream into 19-bit words and writes
// them to instruction memory from address 0, then pulses init. Optional trailer
// checksum is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [18:0]       imem_wdata,
    output logic              init,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE, HDR_LO, HDR_HI, B0, B1, B2, WRITE, CHK, FIN, ERROR
    } state_t;
    localparam state_t AFTER_LAST = CHK;
`else
    typedef enum logic [3:0] {
        IDLE, HDR_LO, HDR_HI, B0, B1, B2, WRITE, FIN, ERROR
    } state_t;
    localparam state_t AFTER_LAST = FIN;
`endif

    // Largest legal word count; 17 bits so 2^16 is representable.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t      state, state_next;
    logic [7:0]  hdr_lo;
    logic [15:0] n_words;
    logic [16:0] wr_cnt;
    logic [7:0]  b0, b1;
    logic [18:0] wdata_q;
    logic        done_q, err_q;
    logic [15:0] hdr_n;
    logic        start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign hdr_n    = {in_byte, hdr_lo};
    assign start_ok = start && (state == IDLE || state == ERROR);
    assign done     = done_q;
    assign err      = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        init       = 1'b0;
        busy       = 1'b1;
        imem_addr  = '0;
        imem_wdata = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = HDR_LO;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = HDR_HI;
            end
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_n == 16'd0)                state_next = AFTER_LAST;
                    else if ({1'b0, hdr_n} > MAX_WORDS) state_next = ERROR;
                    else                               state_next = B0;
                end
            end
            B0: begin
                in_ready = 1'b1;
                if (in_valid) state_next = B1;
            end
            B1: begin
                in_ready = 1'b1;
                if (in_valid) state_next = B2;
            end
            B2: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_byte[7:3] != 5'd0) ? ERROR : WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = wr_cnt[ADDR_W-1:0];
                imem_wdata = wdata_q;
                state_next = (wr_cnt + 17'd1 == {1'b0, n_words}) ? AFTER_LAST : B0;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_byte == csum) ? FIN : ERROR;
            end
`endif
            FIN: begin
                init       = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                busy = 1'b0;
                if (start) state_next = HDR_LO;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_lo  <= '0;
            n_words <= '0;
            wr_cnt  <= '0;
            b0      <= '0;
            b1      <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (start_ok) begin
                wr_cnt <= '0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum   <= '0;
`endif
            end
            if (in_valid && state == HDR_LO) hdr_lo  <= in_byte;
            if (in_valid && state == HDR_HI) n_words <= hdr_n;
            if (in_valid && state == B0)     b0      <= in_byte;
            if (in_valid && state == B1)     b1      <= in_byte;
            if (in_valid && state == B2)     wdata_q <= {in_byte[2:0], b1, b0};
            if (state == WRITE)              wr_cnt  <= wr_cnt + 17'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Trailer byte folds in too, but csum is cleared before it matters.
            if (in_valid && in_ready)        csum    <= csum ^ in_byte;
`endif
            if (state == FIN)                           done_q <= 1'b1;
            if (state != ERROR && state_next == ERROR) err_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/init pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_loader;
    localparam int ADDR_W = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [7:0]        in_byte;
    logic              in_ready, imem_we, init, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [18:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .init(init), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              is_init;
        logic [ADDR_W-1:0] addr;
        logic [18:0]       data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_seen  = 0;
    int  cyc      = 0;
    int  init_cyc = -1;
    int  start_cyc = 0;
    int  wr0;

    logic [7:0] prog [8] = '{8'h02, 8'h00, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07};
    int         gaps [8] = '{1, 0, 3, 2, 0, 1, 4, 2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_seen++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write_kind", 64'(mon_e.is_init), 64'd0);
                check("write_addr", 64'(imem_addr), 64'(mon_e.addr));
                check("write_data", 64'(imem_wdata), 64'(mon_e.data));
            end
        end
        if (init === 1'b1) begin
            init_cyc = cyc;
            check("init_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("init_kind", 64'(mon_e.is_init), 64'd1);
            end
        end
    end

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_wait", 64'(t < 50), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_prog(input logic with_init);
        exp_q.push_back('{1'b0, 12'd0, 19'h12345});
        exp_q.push_back('{1'b0, 12'd1, 19'h7FFFF});
        if (with_init) exp_q.push_back('{1'b1, 12'd0, 19'd0});
    endtask

    task automatic check_all_zero(input string name);
        check(name, {27'd0, in_ready, imem_we, imem_addr, imem_wdata, init, busy, done, err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two words, no stalls.
        push_prog(1'b1);
        wr0 = wr_seen;
        pulse_start();
        for (int i = 0; i < 8; i++) send(prog[i], 0);
        if (CSUM != 0) send(8'h62, 0);
        wait_drain();
        check("s1_done", 64'(done), 64'd1);
        check("s1_err", 64'(err), 64'd0);
        check("s1_busy", 64'(busy), 64'd0);
        check("s1_writes", 64'(wr_seen - wr0), 64'd2);
        check("s1_latency", 64'(init_cyc - start_cyc), 64'(11 + CSUM));

        // Illegal upper bits in B2.
        wr0 = wr_seen;
        pulse_start();
        check("s2_done_cleared", 64'(done), 64'd0);
        send(8'h01, 0); send(8'h00, 0);
        send(8'h00, 0); send(8'h00, 0); send(8'h08, 0);
        check("s2_err", 64'(err), 64'd1);
        check("s2_ready", 64'(in_ready), 64'd0);
        check("s2_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("s2_writes", 64'(wr_seen - wr0), 64'd0);
        check("s2_err_sticky", 64'(err), 64'd1);

        // Empty program, restarting out of ERROR.
        exp_q.push_back('{1'b1, 12'd0, 19'd0});
        wr0 = wr_seen;
        pulse_start();
        check("s3_err_cleared", 64'(err), 64'd0);
        send(8'h00, 0); send(8'h00, 0);
        if (CSUM != 0) send(8'h00, 0);
        wait_drain();
        check("s3_done", 64'(done), 64'd1);
        check("s3_writes", 64'(wr_seen - wr0), 64'd0);
        check("s3_latency", 64'(init_cyc - start_cyc), 64'(3 + CSUM));

        // Same program with in_valid gaps.
        push_prog(1'b1);
        wr0 = wr_seen;
        pulse_start();
        for (int i = 0; i < 8; i++) send(prog[i], gaps[i]);
        if (CSUM != 0) send(8'h62, 2);
        wait_drain();
        check("s4_done", 64'(done), 64'd1);
        check("s4_writes", 64'(wr_seen - wr0), 64'd2);

        // Reset after B1 of the first word, then a fresh session.
        wr0 = wr_seen;
        pulse_start();
        for (int i = 0; i < 4; i++) send(prog[i], 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("s5_reset_outputs");
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("s5_no_write", 64'(wr_seen - wr0), 64'd0);
        check_all_zero("s5_idle_outputs");
        push_prog(1'b1);
        pulse_start();
        for (int i = 0; i < 8; i++) send(prog[i], 0);
        if (CSUM != 0) send(8'h62, 0);
        wait_drain();
        check("s5_fresh_done", 64'(done), 64'd1);
        check("s5_fresh_writes", 64'(wr_seen - wr0), 64'd2);

        // Header boundary: 4096 accepted, 4097 rejected.
        wr0 = wr_seen;
        pulse_start();
        send(8'h00, 0); send(8'h10, 0);
        check("s6_max_busy", 64'(busy), 64'd1);
        check("s6_max_err", 64'(err), 64'd0);
        check("s6_max_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_start();
        send(8'h01, 0); send(8'h10, 0);
        check("s6_over_err", 64'(err), 64'd1);
        check("s6_over_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("s6_writes", 64'(wr_seen - wr0), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Corrupted trailer: writes land, session fails without init.
        push_prog(1'b0);
        wr0 = wr_seen;
        pulse_start();
        for (int i = 0; i < 8; i++) send(prog[i], 0);
        send(8'h63, 0);
        wait_drain();
        repeat (3) @(posedge clk); #1;
        check("s7_err", 64'(err), 64'd1);
        check("s7_done", 64'(done), 64'd0);
        check("s7_writes", 64'(wr_seen - wr0), 64'd2);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle core. Accepts a byte stream over a valid/ready handshake, packs it into 19-bit instruction words, and writes them sequentially into instruction memory from address 0. On successful completion, it pulses `init` into the core's controller to start execution. The core must not fetch while `busy` is high.

## Interface

Parameters:
- `ADDR_W`, default 12: instruction memory address width. Maximum program length is 2^ADDR_W words.

Ports:
- `clk`: input, 1 bit. Single clock for the whole block.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `start`: input, 1 bit. One-cycle request to begin a load session.
- `in_valid`: input, 1 bit. Byte source has data.
- `in_byte`: input, 8 bits. Stream byte.
- `in_ready`: output, 1 bit. Loader accepts a byte this cycle.
- `imem_we`: output, 1 bit. Instruction memory write strobe.
- `imem_addr`: output, ADDR_W bits. Write address.
- `imem_wdata`: output, 19 bits. Instruction word.
- `init`: output, 1 bit. One-cycle start pulse to the core controller.
- `busy`: output, 1 bit. Session in progress.
- `done`: output, 1 bit. Last session succeeded. Sticky until the next `start` or `rst`.
- `err`: output, 1 bit. Last session failed. Sticky until the next `start` or `rst`.

## Operation

- A byte is accepted only in a cycle where `in_valid` and `in_ready` are both high.
- State machine states: IDLE, HDR_LO, HDR_HI, B0, B1, B2, WRITE, CHK, FIN, ERROR.
- IDLE:
  - `in_ready` = 0.
  - `start` clears `done` and `err` and moves to HDR_LO.
  - `start` is ignored in every other state except ERROR.
- HDR_LO/HDR_HI: header is a 16-bit word count N, sent little-endian.
  - N = 0 → FIN (CHK first when checksum is enabled).
  - N > 2^ADDR_W → ERROR.
  - Otherwise → B0.
- B0/B1/B2: each instruction word is three bytes, little-endian.
  - wdata[7:0] = B0.
  - wdata[15:8] = B1.
  - wdata[18:16] = B2[2:0].
  - B2[7:3] ≠ 0 → ERROR, and no write is issued for that word.
- WRITE:
  - `imem_we` = 1 for exactly one cycle; `in_ready` = 0.
  - Address counter then increments.
  - If the words written equal N → CHK or FIN; otherwise → B0.
- Address counter: cleared on `start`, starts at 0, never wraps within a session (guaranteed by the header check).
- FIN: `init` = 1 for one cycle, `done` set, → IDLE.
- ERROR:
  - `err` = 1, `in_ready` = 0, no writes, no `init`.
  - Exits only on `start` (restarts a session) or `rst`.
  - Words already written stay in memory.
- `busy` = 1 in every state except IDLE and ERROR.

## Timing

- Reset: state IDLE and address counter 0. All outputs are 0: `in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `init`, `busy`, `done`, `err`.
- State is registered. `in_ready` and `imem_we` are decoded from the registered state only, never from `in_valid`.
- `imem_we`, `imem_addr` and `imem_wdata` are valid in the cycle after B2 is accepted.
- Minimum session length with no stalls, counted from the `start` cycle to `init`: 2 + 4N + 1 cycles, plus 1 cycle with the checksum enabled.
- `in_valid` gaps stall the FSM in its current state. Partial word bytes are held.
- `rst` mid-session has priority over everything:
  - The FSM returns to IDLE on the next edge.
  - No further writes are issued.
  - The next session starts at address 0.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last word, or after the header when N = 0, state CHK expects one trailer byte equal to the XOR of every prior session byte, header included.
  - Match → FIN.
  - Mismatch → ERROR, with no `init`.
- Macro not defined:
  - No CHK state and no trailer byte.
  - WRITE of the last word goes directly to FIN.

## Test plan

- Load two words, no stalls. Stream: `start`, then bytes 02 00 45 23 01 FF FF 07, plus 62 when `IMEM_LOADER_CHECKSUM_EN` is defined. Required response:
  - Write of addr 0 = 0x12345.
  - Write of addr 1 = 0x7FFFF.
  - One `init` pulse, then `done` = 1, `err` = 0.
  - Exactly 2 `imem_we` cycles.
- Illegal upper bits: header 01 00, then bytes 00 00 08. Required response: `err` = 1, no `imem_we`, no `init`, `in_ready` = 0 afterwards.
- Empty program: header 00 00 (plus trailer 00 when checksum is enabled). Required response: `init` pulse in the next cycle, `done` = 1, zero writes.
- Backpressure and reset:
  - Drive random `in_valid` gaps during scenario 1. Writes and data must be identical to the no-stall case.
  - Assert `rst` after B1 of word 1. All outputs must read 0, and no write occurs.
  - A fresh session must then write addr 0 first.
- Oversize header: N = 4097 with ADDR_W = 12. Required response: `err` = 1 immediately after HDR_HI, zero writes.
- Checksum enabled, trailer byte corrupted (0x63 instead of 0x62 in scenario 1). Required response: both writes occur, `err` = 1, no `init`, `done` = 0.
